// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with byte-enable stores done as read-modify-write.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_gnt,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_gnt,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner_p0;
  logic        win;
  logic        capture;
  logic        load_rdata;
  logic        save_old;
  logic        misaligned;
  logic [31:0] word_addr;

  logic        cap_we_p0;
  logic [31:0] cap_addr_p0;
  logic [31:0] cap_wdata_p0;
  logic [3:0]  cap_be_p0;
  logic [31:0] old_word_p1;

  function automatic logic [31:0] merge_bytes(input logic [31:0] new_word,
                                              input logic [31:0] old_word,
                                              input logic [3:0]  be);
    logic [31:0] m;
    m = old_word;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return m;
  endfunction

`ifdef DMEM_ARB_RR_EN
  // rr_ptr names the port that wins the next tie; it flips away from whoever was just granted.
  logic rr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
    end else if (state == DONE) begin
      rr_ptr <= ~owner_p0;
    end
  end

  always_comb begin
    win = (p0_req && p1_req) ? rr_ptr : ~p0_req;
  end
`else
  always_comb begin
    win = ~p0_req;
  end
`endif

  assign misaligned = (cap_addr_p0[1:0] != 2'b00);
  assign word_addr  = {cap_addr_p0[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        owner_p0 <= win;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    capture    = 1'b0;
    load_rdata = 1'b0;
    save_old   = 1'b0;
    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          capture   = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr   = word_addr;
        load_rdata = 1'b1;
        state_nxt  = DONE;
        // Misaligned and empty-mask stores fall through to DONE without touching memory.
        if (cap_we_p0 && !misaligned) begin
          if (&cap_be_p0) begin
            mem_we    = 1'b1;
            mem_wdata = cap_wdata_p0;
          end else if (|cap_be_p0) begin
            save_old  = 1'b1;
            state_nxt = MERGE;
          end
        end
      end
      MERGE: begin
        mem_addr  = word_addr;
        mem_we    = 1'b1;
        mem_wdata = merge_bytes(cap_wdata_p0, old_word_p1, cap_be_p0);
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request capture stage: winner's fields latched on leaving IDLE.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_we_p0    <= win ? p1_we    : p0_we;
      cap_addr_p0  <= win ? p1_addr  : p0_addr;
      cap_wdata_p0 <= win ? p1_wdata : p0_wdata;
      cap_be_p0    <= win ? p1_be    : p0_be;
    end
    if (save_old) begin
      old_word_p1 <= mem_rdata;
    end
  end

  // Per-port read data holds between grants, so it lives in reset-cleared registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_rdata <= 32'h0;
      p1_rdata <= 32'h0;
    end else if (load_rdata) begin
      if (owner_p0) begin
        p1_rdata <= cap_we_p0 ? 32'h0 : mem_rdata;
      end else begin
        p0_rdata <= cap_we_p0 ? 32'h0 : mem_rdata;
      end
    end
  end

  always_comb begin
    p0_gnt = (state == DONE) && !owner_p0;
    p1_gnt = (state == DONE) &&  owner_p0;
    p0_err = p0_gnt && misaligned;
    p1_err = p1_gnt && misaligned;
  end

endmodule
